card_cursor_sel: RTL and testbench
==================================

Name: card_cursor_sel

Overview:
- Parametrised cursor and two-card selection controller for the card-matching game board.
- Moves a pointer over a ROWS x COLS grid in four directions. Skips removed cards and the card already chosen this turn.
- Latches two chosen cards and presents them as a pair to the match/score logic.
- Replaces the single-axis, single-skip pointer. Sits between the debounced button pulses and the game controller.

Parameters:
NUM_CARDS, 16, total cards on the board; indices 0..NUM_CARDS-1; must be a multiple of COLS
COLS, 4, cards per row; north/south step size
PW, 5, width of pointer and choice outputs; 2^PW >= NUM_CARDS

Ports:
new_clk  in  1  system clock
rst  in  1  synchronous, active-high reset
east  in  1  move +1 pulse, one cycle
west  in  1  move -1 pulse
north  in  1  move -COLS pulse
south  in  1  move +COLS pulse
select  in  1  choose the card under the cursor
pair_ack  in  1  game controller consumed the pair
removed  in  NUM_CARDS  bit i=1: card i is matched and off the board
point  out  PW  current cursor index
choose_1  out  PW  first chosen card
choose_2  out  PW  second chosen card
c1_valid  out  1  choose_1 holds a live choice
pair_valid  out  1  choose_1/choose_2 form a complete pair

Behaviour:
- Reset: rst is synchronous, active-high; clock is new_clk. On reset: point=0, choose_1=0, choose_2=0, c1_valid=0, pair_valid=0, FSM=IDLE. Reset overrides all inputs, mid-move or mid-pair.
- Eligible(i): removed[i]==0 AND NOT (c1_valid AND i==choose_1).
- Move priority, one move per cycle: east > west > north > south. Lower-priority pulses in the same cycle are dropped.
- Move latency: point updates on the new_clk edge that samples the pulse.
- East/west: step +1/-1 mod NUM_CARDS. Repeat until the first eligible index is found, searching at most NUM_CARDS-1 steps. If none is eligible, point holds.
- North/south: step -COLS/+COLS mod NUM_CARDS, staying in the same column. Skip ineligible cards the same way. If no eligible card exists in the column, point holds.
- Auto-evict: with no move pulse, if removed[point]==1, point advances as an east move. If no card is eligible, point holds.
- FSM states:
  - IDLE: select with removed[point]==0 -> choose_1=point, c1_valid=1 -> ONE.
  - ONE: select with point!=choose_1 and removed[point]==0 -> choose_2=point, pair_valid=1 -> PAIR. select on choose_1 or on a removed card is ignored.
  - PAIR: select ignored; moves still allowed. pair_ack -> c1_valid=0, pair_valid=0, choose_1/choose_2 hold their values -> IDLE.
- select and a move pulse in the same cycle: the select latches the pre-move point, then the cursor moves.
- select and pair_ack in the same cycle while in PAIR: ack is processed; select is ignored.
- pair_ack outside PAIR: no effect.
- If removed[choose_1] rises while in ONE: c1_valid clears and the FSM returns to IDLE.

Optional Feature:
- CURSOR_WRAP_EN defined: all moves wrap modulo the board as above.
- CURSOR_WRAP_EN undefined: moves saturate.
  - east stops at the last eligible index <= NUM_CARDS-1.
  - west stops at the first eligible index >= 0.
  - north/south stay within row 0..ROWS-1 of the column.
  - If no eligible card lies in the move direction before the edge, point holds.
- Auto-evict behaves the same in both builds, except that without wrap it searches east, then west.

Test Plan:
- Reset, then east x3 with removed=0 -> point 1,2,3. With CURSOR_WRAP_EN, point=15 then east -> 0; without it, point stays 15.
- point=4, select -> choose_1=4, c1_valid=1. Then point=3, east -> 5 (skips 4). west from 5 -> 3.
- removed=16'h0022 (cards 1, 5 removed), point=9, north -> 13 (col 1: 5 removed, 1 removed, wraps). Without wrap -> point holds 9.
- IDLE, select at 2, move, select at 7 -> pair_valid=1, choose_1=2, choose_2=7. select at 8 ignored. pair_ack -> pair_valid=0, c1_valid=0.
- point=6, removed[6] rises with no move -> next cycle point=7. Set removed=all ones -> point holds.
- east and west asserted together at point=3 -> point=4. Assert rst mid-PAIR -> all outputs 0, FSM=IDLE.

Source files
------------

// File: rtl/card_cursor_sel.sv
// card_cursor_sel: four-direction board cursor with two-card pair selection.
// Build option CURSOR_WRAP_EN: moves wrap modulo the board; when undefined, moves saturate at the edges.
module card_cursor_sel #(
    parameter int NUM_CARDS = 16,
    parameter int COLS      = 4,
    parameter int PW        = 5
) (
    input  logic                 new_clk,
    input  logic                 rst,
    input  logic                 east_i,
    input  logic                 west_i,
    input  logic                 north_i,
    input  logic                 south_i,
    input  logic                 select_i,
    input  logic                 pair_ack_i,
    input  logic [NUM_CARDS-1:0] removed_i,
    output logic [PW-1:0]        point_o,
    output logic [PW-1:0]        choose_1_o,
    output logic [PW-1:0]        choose_2_o,
    output logic                 c1_valid_o,
    output logic                 pair_valid_o
);
    // state | meaning
    // IDLE  | no card chosen this turn
    // ONE   | choose_1 latched, waiting for a second card
    // PAIR  | pair presented, waiting for pair_ack
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ONE  = 2'd1;
    localparam logic [1:0] PAIR = 2'd2;

    localparam int ROWS = NUM_CARDS / COLS;
    localparam int SPAN = 2 ** PW;
`ifdef CURSOR_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic [1:0]      state_q, state_d;
    logic [PW-1:0]   point_q, point_d;
    logic [PW-1:0]   choose_1_q, choose_1_d;
    logic [PW-1:0]   choose_2_q, choose_2_d;
    logic [SPAN-1:0] rem_ext, c1_mask, elig;
    logic [PW-1:0]   e_idx, w_idx, n_idx, s_idx, t;
    logic            e_ok, w_ok, n_ok, s_ok;
    int              p;

    // Indices past the board read as removed so they are never eligible.
    always_comb begin
        rem_ext                = '1;
        rem_ext[NUM_CARDS-1:0] = removed_i;
        c1_mask                = {{(SPAN-1){1'b0}}, (state_q != IDLE)} << choose_1_q;
        elig                   = ~rem_ext & ~c1_mask;
    end

    // Searches run from the farthest step down so the nearest eligible card wins.
    always_comb begin
        p     = int'(point_q);
        t     = '0;
        e_ok  = 1'b0;
        w_ok  = 1'b0;
        n_ok  = 1'b0;
        s_ok  = 1'b0;
        e_idx = point_q;
        w_idx = point_q;
        n_idx = point_q;
        s_idx = point_q;
        for (int k = NUM_CARDS - 1; k >= 1; k--) begin
            t = PW'((p + k) % NUM_CARDS);
            if ((WRAP || (p + k < NUM_CARDS)) && elig[t]) begin
                e_ok  = 1'b1;
                e_idx = t;
            end
            t = PW'((p + NUM_CARDS - k) % NUM_CARDS);
            if ((WRAP || (p >= k)) && elig[t]) begin
                w_ok  = 1'b1;
                w_idx = t;
            end
        end
        for (int k = ROWS - 1; k >= 1; k--) begin
            t = PW'((p + NUM_CARDS - k * COLS) % NUM_CARDS);
            if ((WRAP || (p >= k * COLS)) && elig[t]) begin
                n_ok  = 1'b1;
                n_idx = t;
            end
            t = PW'((p + k * COLS) % NUM_CARDS);
            if ((WRAP || (p + k * COLS < NUM_CARDS)) && elig[t]) begin
                s_ok  = 1'b1;
                s_idx = t;
            end
        end
    end

    // Unfound searches return point_q, so a failed move simply holds.
    always_comb begin
        point_d = point_q;
        if (east_i) begin
            point_d = e_idx;
        end else if (west_i) begin
            point_d = w_idx;
        end else if (north_i) begin
            point_d = n_idx;
        end else if (south_i) begin
            point_d = s_idx;
        end else if (rem_ext[point_q]) begin
            point_d = e_ok ? e_idx : w_idx;
        end
    end

    always_comb begin
        state_d    = state_q;
        choose_1_d = choose_1_q;
        choose_2_d = choose_2_q;
        case (state_q)
            IDLE: begin
                if (select_i && !rem_ext[point_q]) begin
                    choose_1_d = point_q;
                    state_d    = ONE;
                end
            end
            ONE: begin
                if (rem_ext[choose_1_q]) begin
                    state_d = IDLE;
                end else if (select_i && (point_q != choose_1_q) && !rem_ext[point_q]) begin
                    choose_2_d = point_q;
                    state_d    = PAIR;
                end
            end
            PAIR: begin
                if (pair_ack_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge new_clk) begin
        if (rst) begin
            state_q    <= IDLE;
            point_q    <= '0;
            choose_1_q <= '0;
            choose_2_q <= '0;
        end else begin
            state_q    <= state_d;
            point_q    <= point_d;
            choose_1_q <= choose_1_d;
            choose_2_q <= choose_2_d;
        end
    end

    assign point_o      = point_q;
    assign choose_1_o   = choose_1_q;
    assign choose_2_o   = choose_2_q;
    assign c1_valid_o   = (state_q != IDLE);
    assign pair_valid_o = (state_q == PAIR);

endmodule

// File: tb/tb_card_cursor_sel.sv
// Bench for card_cursor_sel: directed board scenarios plus random traffic against a list-based model.
// Honours CURSOR_WRAP_EN the same way the design does.
module tb_card_cursor_sel;
    localparam int NC   = 16;
    localparam int COLS = 4;
    localparam int ROWS = NC / COLS;
    localparam int PW   = 5;
    localparam int IW   = $clog2(NC);
`ifdef CURSOR_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic          new_clk = 1'b0;
    logic          rst = 1'b1;
    logic          east = 1'b0, west = 1'b0, north = 1'b0, south = 1'b0;
    logic          select = 1'b0, pair_ack = 1'b0;
    logic [NC-1:0] removed = '0;
    logic [PW-1:0] point_o, choose_1_o, choose_2_o;
    logic          c1_valid_o, pair_valid_o;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Model: cursor index, chosen cards and how many cards are held (0, 1 or 2 = pair).
    int m_pt = 0, m_c1 = 0, m_c2 = 0, m_held = 0;

    card_cursor_sel #(.NUM_CARDS(NC), .COLS(COLS), .PW(PW)) dut (
        .new_clk     (new_clk),
        .rst         (rst),
        .east_i      (east),
        .west_i      (west),
        .north_i     (north),
        .south_i     (south),
        .select_i    (select),
        .pair_ack_i  (pair_ack),
        .removed_i   (removed),
        .point_o     (point_o),
        .choose_1_o  (choose_1_o),
        .choose_2_o  (choose_2_o),
        .c1_valid_o  (c1_valid_o),
        .pair_valid_o(pair_valid_o)
    );

    always #5 new_clk = ~new_clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // List the cells a move visits in order, then take the first one that is still playable.
    function automatic int mv(input int p, input int dir, input int held, input int c1,
                              input logic [NC-1:0] rem);
        int path[$];
        int step, lim, t, res;
        bit found;
        step  = (dir == 0) ? 1 : (dir == 1) ? -1 : (dir == 2) ? -COLS : COLS;
        lim   = (dir < 2) ? NC - 1 : ROWS - 1;
        res   = p;
        found = 1'b0;
        for (int k = 1; k <= lim; k++) begin
            t = p + k * step;
            if (!WRAP && (t < 0 || t >= NC)) break;
            path.push_back(((t % NC) + NC) % NC);
        end
        foreach (path[j]) begin
            t = path[j];
            if (!found && rem[t[IW-1:0]] == 1'b0 && !(held != 0 && t == c1)) begin
                found = 1'b1;
                res   = t;
            end
        end
        return res;
    endfunction

    always @(posedge new_clk) begin
        int np;
        int pt;
        pt = m_pt;
        np = m_pt;
        if (rst) begin
            m_pt   <= 0;
            m_c1   <= 0;
            m_c2   <= 0;
            m_held <= 0;
        end else begin
            if (east)       np = mv(pt, 0, m_held, m_c1, removed);
            else if (west)  np = mv(pt, 1, m_held, m_c1, removed);
            else if (north) np = mv(pt, 2, m_held, m_c1, removed);
            else if (south) np = mv(pt, 3, m_held, m_c1, removed);
            else if (removed[pt[IW-1:0]]) begin
                np = mv(pt, 0, m_held, m_c1, removed);
                if (np == pt) np = mv(pt, 1, m_held, m_c1, removed);
            end
            m_pt <= np;
            if (m_held == 0) begin
                if (select && !removed[pt[IW-1:0]]) begin
                    m_c1   <= pt;
                    m_held <= 1;
                end
            end else if (m_held == 1) begin
                if (removed[m_c1[IW-1:0]]) m_held <= 0;
                else if (select && pt != m_c1 && !removed[pt[IW-1:0]]) begin
                    m_c2   <= pt;
                    m_held <= 2;
                end
            end else if (pair_ack) begin
                m_held <= 0;
            end
        end
    end

    always @(negedge new_clk) begin
        if (chk_en) begin
            chk("point", int'(point_o), m_pt);
            chk("choose_1", int'(choose_1_o), m_c1);
            chk("choose_2", int'(choose_2_o), m_c2);
            chk("c1_valid", int'(c1_valid_o), int'(m_held != 0));
            chk("pair_valid", int'(pair_valid_o), int'(m_held == 2));
        end
    end

    task automatic cyc(input bit e, input bit w, input bit n, input bit s, input bit sel, input bit ack);
        east = e; west = w; north = n; south = s; select = sel; pair_ack = ack;
        @(negedge new_clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(0, 0, 0, 0, 0, 0);
        rst = 1'b0;
    endtask

    initial begin
        logic [IW-1:0] ridx;
        do_reset();
        do_reset();
        chk_en = 1'b1;
        chk("rst_point", int'(point_o), 0);
        chk("rst_c1_valid", int'(c1_valid_o), 0);
        chk("rst_pair_valid", int'(pair_valid_o), 0);

        cyc(1, 0, 0, 0, 0, 0); chk("east1", int'(point_o), 1);
        cyc(1, 0, 0, 0, 0, 0); chk("east2", int'(point_o), 2);
        cyc(1, 0, 0, 0, 0, 0); chk("east3", int'(point_o), 3);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 0, 0); chk("south_to_15", int'(point_o), 15);
        cyc(1, 0, 0, 0, 0, 0); chk("east_edge", int'(point_o), WRAP ? 0 : 15);

        do_reset();
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);
        chk("sel_c1", int'(choose_1_o), 4);
        chk("sel_c1_valid", int'(c1_valid_o), 1);
        cyc(0, 1, 0, 0, 0, 0); chk("west_to_3", int'(point_o), 3);
        cyc(1, 0, 0, 0, 0, 0); chk("east_skip_chosen", int'(point_o), 5);
        cyc(0, 1, 0, 0, 0, 0); chk("west_skip_chosen", int'(point_o), 3);

        do_reset();
        removed = 16'h0022;
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(1, 0, 0, 0, 0, 0); chk("at_9", int'(point_o), 9);
        cyc(0, 0, 1, 0, 0, 0); chk("north_skip", int'(point_o), WRAP ? 13 : 9);

        removed = '0;
        do_reset();
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);
        chk("pair_valid", int'(pair_valid_o), 1);
        chk("pair_c1", int'(choose_1_o), 2);
        chk("pair_c2", int'(choose_2_o), 7);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);
        chk("pair_sel_ignored", int'(choose_2_o), 7);
        cyc(0, 0, 0, 0, 0, 1);
        chk("ack_pair_valid", int'(pair_valid_o), 0);
        chk("ack_c1_valid", int'(c1_valid_o), 0);
        chk("ack_c1_hold", int'(choose_1_o), 2);

        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0); chk("at_6", int'(point_o), 6);
        removed = 16'h0040;
        cyc(0, 0, 0, 0, 0, 0); chk("evict", int'(point_o), 7);
        removed = '1;
        cyc(0, 0, 0, 0, 0, 0); chk("evict_none", int'(point_o), 7);
        removed = '0;
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0); chk("at_3", int'(point_o), 3);
        cyc(1, 1, 0, 0, 0, 0); chk("east_beats_west", int'(point_o), 4);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0); chk("pair_before_rst", int'(pair_valid_o), 1);
        do_reset();
        chk("rst_mid_point", int'(point_o), 0);
        chk("rst_mid_c1", int'(choose_1_o), 0);
        chk("rst_mid_c2", int'(choose_2_o), 0);
        chk("rst_mid_pair", int'(pair_valid_o), 0);

        for (int i = 0; i < 4000; i++) begin
            int r;
            bit e, w, n, s;
            r = int'($urandom_range(0, 15));
            e = (r == 0); w = (r == 1); n = (r == 2); s = (r == 3);
            if ($urandom_range(0, 9) == 0) begin
                e = 1'($urandom_range(0, 1)); w = 1'($urandom_range(0, 1));
                n = 1'($urandom_range(0, 1)); s = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 7) == 0) begin
                ridx = IW'($urandom_range(0, NC - 1));
                removed[ridx] = ~removed[ridx];
            end
            if ($urandom_range(0, 199) == 0) removed = '0;
            if ($urandom_range(0, 399) == 0) removed = '1;
            rst = ($urandom_range(0, 499) == 0);
            cyc(e, w, n, s, $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0);
        end
        rst = 1'b0;
        cyc(0, 0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
